// File: rtl/mem_responder_pkg.sv
// Types and helpers local to the memory responder: queue entry, FSM state and
// byte-lane mask expansion.
package mem_responder_pkg;

  import memory_io_pkg::*;

  typedef struct packed {
    logic [31:0]           addr;
    logic [31:0]           data;
    logic [3:0]            do_read;
    logic [3:0]            do_write;
    logic [USER_TAG_W-1:0] user_tag;
  } mem_resp_entry_t;

  typedef enum logic {
    IDLE,
    BUSY
  } mem_resp_state_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] en);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{en[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/memory_io_pkg.sv
// Shared memory_io request/response transaction types used by initiators and
// memory-side responders.
package memory_io_pkg;

  localparam int USER_TAG_W = 8;

  typedef struct packed {
    logic [31:0]           addr;
    logic [31:0]           data;
    logic [3:0]            do_read;
    logic [3:0]            do_write;
    logic                  valid;
    logic                  dummy;
    logic [USER_TAG_W-1:0] user_tag;
  } memory_io_req;

  typedef struct packed {
    logic [31:0]           addr;
    logic [31:0]           data;
    logic                  valid;
    logic                  ready;
    logic                  dummy;
    logic [USER_TAG_W-1:0] user_tag;
  } memory_io_rsp;

endpackage

// File: rtl/mem_responder_req_fifo.sv
// Synchronous FIFO of arbitrary entry type with head read, simultaneous
// push/pop and an occupancy count.
module req_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  entry_t          slots [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = slots[rd_ptr_q];

  // A push while full is refused even if a pop frees a slot this cycle.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: queues memory_io requests in order, services each
// against a word store after a fixed access time, and returns one response each.
module mem_responder
  import memory_io_pkg::*;
  import mem_responder_pkg::*;
#(
  parameter int    MEM_WORDS     = 16384,
  parameter int    ACCESS_CYCLES = 2,
  parameter int    QDEPTH        = 4,
  parameter string INIT_FILE     = ""
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req mem_req,
  output memory_io_rsp mem_rsp,
  output logic         overflow,
  output logic         busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  logic [31:0] store [MEM_WORDS];

  mem_resp_entry_t       push_entry, head_entry;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(QDEPTH):0] fifo_count;

  mem_resp_state_e       state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  mem_resp_entry_t       active_q, active_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_addr_q, rsp_addr_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [USER_TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic                  overflow_q, overflow_d;

  logic [AW-1:0]         word_idx;
  logic [31:0]           store_rd_word, merged_word, wr_mask;
  logic                  store_we;
  logic                  unused_ok;

  assign push_entry = '{addr:     mem_req.addr,
                        data:     mem_req.data,
                        do_read:  mem_req.do_read,
                        do_write: mem_req.do_write,
                        user_tag: mem_req.user_tag};
  assign fifo_push  = mem_req.valid && !fifo_full;

  req_fifo #(
    .DEPTH   (QDEPTH),
    .entry_t (mem_resp_entry_t)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Upper address bits fall away here, so the store aliases modulo its size.
  assign word_idx      = active_q.addr[AW+1:2];
  assign store_rd_word = store[word_idx];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    fifo_pop    = 1'b0;
    store_we    = 1'b0;
    wr_mask     = lane_mask(active_q.do_write);
    merged_word = (store_rd_word & ~wr_mask) | (active_q.data & wr_mask);
    overflow_d  = overflow_q | (mem_req.valid & fifo_full);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          active_d = head_entry;
          cnt_d    = CNT_LOAD;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Read data reflects this request's own write, masked per lane.
          store_we    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_addr_d  = active_q.addr;
          rsp_data_d  = merged_word & lane_mask(active_q.do_read);
          rsp_tag_d   = active_q.user_tag;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      active_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store_we) store[word_idx] <= merged_word;
  end

  always_comb begin
    mem_rsp          = '0;
    mem_rsp.addr     = rsp_addr_q;
    mem_rsp.data     = rsp_data_q;
    mem_rsp.valid    = rsp_valid_q;
    mem_rsp.ready    = ~fifo_full;
    mem_rsp.dummy    = 1'b0;
    mem_rsp.user_tag = rsp_tag_q;
  end

  assign overflow  = overflow_q;
  assign busy      = !fifo_empty || (state_q != IDLE);
  assign unused_ok = ^{mem_req.dummy, fifo_count};

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed cases plus randomized traffic
// checked against a word-array reference model.
module tb_mem_responder;
  import memory_io_pkg::*;

  localparam int MEM_WORDS     = 16384;
  localparam int ACCESS_CYCLES = 2;
  localparam int QDEPTH        = 4;
  localparam int SPACING       = ACCESS_CYCLES + 1;

  logic         clk = 1'b0;
  logic         reset;
  memory_io_req mem_req;
  memory_io_rsp mem_rsp;
  logic         overflow;
  logic         busy;

  mem_responder #(
    .MEM_WORDS     (MEM_WORDS),
    .ACCESS_CYCLES (ACCESS_CYCLES),
    .QDEPTH        (QDEPTH),
    .INIT_FILE     ("")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_rsp  (mem_rsp),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [int];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rsp_cyc[$];
  int          n_rsp = 0;
  int          last_push_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: byte-addressed memory seen as words, wrapping modulo size.
  function automatic logic [31:0] model_access(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] rd, input logic [3:0] wr);
    int          idx;
    logic [31:0] w;
    logic [31:0] r;
    idx = int'((addr / 4) % MEM_WORDS);
    w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (wr[i]) w[8*i +: 8] = data[8*i +: 8];
      if (rd[i]) r[8*i +: 8] = w[8*i +: 8];
    end
    ref_mem[idx] = w;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && mem_rsp.valid) begin
      rsp_cyc.push_back(cyc);
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got addr %h tag %h, expected no response", mem_rsp.addr, mem_rsp.user_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_addr", mem_rsp.addr, mon_e.addr);
        check("rsp_data", mem_rsp.data, mon_e.data);
        check("rsp_tag", {24'h0, mem_rsp.user_tag}, {24'h0, mon_e.tag});
        check("rsp_dummy", {31'h0, mem_rsp.dummy}, 32'h0);
      end
    end
  end

  // Called at a negedge; drives one request for one clock.
  task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] rd,
                      input logic [3:0] wr, input logic [7:0] tag, input bit accept);
    exp_t e;
    mem_req.addr     = addr;
    mem_req.data     = data;
    mem_req.do_read  = rd;
    mem_req.do_write = wr;
    mem_req.user_tag = tag;
    mem_req.dummy    = 1'b0;
    mem_req.valid    = 1'b1;
    check("ready_at_push", {31'h0, mem_rsp.ready}, {31'h0, accept});
    if (accept) begin
      e.addr = addr;
      e.data = model_access(addr, data, rd, wr);
      e.tag  = tag;
      exp_q.push_back(e);
    end
    @(negedge clk);
    last_push_cyc = cyc;
    mem_req.valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_pending"}, exp_q.size(), 32'h0);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int push_c;
    int s;
    int n0;
    logic [31:0] a;
    bit acc_pat [7];

    reset   = 1'b1;
    mem_req = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, mem_rsp.valid}, 32'h0);
    check("rst_ready", {31'h0, mem_rsp.ready}, 32'h1);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_addr", mem_rsp.addr, 32'h0);
    check("rst_data", mem_rsp.data, 32'h0);
    check("rst_tag", {24'h0, mem_rsp.user_tag}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Write then read, with first-transaction latency.
    send(32'h100, 32'hDEADBEEF, 4'h0, 4'hF, 8'd5, 1'b1);
    push_c = last_push_cyc;
    drain("wr1");
    check("latency", rsp_cyc[rsp_cyc.size()-1] - push_c, 32'd3);
    send(32'h100, 32'h0, 4'hF, 4'h0, 8'd6, 1'b1);
    drain("rd1");

    // Byte enables, partial read lanes, ignored low address bits.
    send(32'h100, 32'h0000AA00, 4'h0, 4'b0010, 8'd7, 1'b1);
    send(32'h100, 32'h0, 4'hF, 4'h0, 8'd8, 1'b1);
    send(32'h100, 32'h0, 4'b0011, 4'h0, 8'd9, 1'b1);
    send(32'h103, 32'h0, 4'hF, 4'h0, 8'd10, 1'b1);
    send(32'h100, 32'h0, 4'h0, 4'h0, 8'd11, 1'b1);
    drain("bytes");

    // Address wrap.
    send(32'(MEM_WORDS * 4 + 8), 32'h11111111, 4'h0, 4'hF, 8'd12, 1'b1);
    send(32'h8, 32'h0, 4'hF, 4'h0, 8'd13, 1'b1);
    drain("wrap");

    // Back-to-back burst until the queue fills; the request sent at full is dropped.
    check("ovf_before", {31'h0, overflow}, 32'h0);
    acc_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    s  = rsp_cyc.size();
    n0 = n_rsp;
    for (int i = 0; i < 7; i++) begin
      send(32'h200 + 32'(4 * i), $urandom, 4'hF, 4'hF, 8'(20 + i), acc_pat[i]);
    end
    check("ovf_after", {31'h0, overflow}, 32'h1);
    drain("burst");
    check("burst_count", n_rsp - n0, 32'd6);
    for (int i = 1; i < 6; i++) begin
      if (s + i < rsp_cyc.size())
        check("burst_spacing", rsp_cyc[s+i] - rsp_cyc[s+i-1], SPACING);
    end
    check("ovf_sticky", {31'h0, overflow}, 32'h1);

    // Reset while busy with two requests still queued.
    send(32'h100, 32'h0, 4'hF, 4'h0, 8'd30, 1'b1);
    send(32'h100, 32'h0, 4'hF, 4'h0, 8'd31, 1'b1);
    send(32'h8, 32'h0, 4'hF, 4'h0, 8'd32, 1'b1);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", {31'h0, mem_rsp.valid}, 32'h0);
    check("mid_rst_ready", {31'h0, mem_rsp.ready}, 32'h1);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_overflow", {31'h0, overflow}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    n0 = n_rsp;
    repeat (10) @(negedge clk);
    check("post_rst_no_rsp", n_rsp - n0, 32'h0);
    send(32'h100, 32'h0, 4'hF, 4'h0, 8'd33, 1'b1);
    send(32'h8, 32'h0, 4'hF, 4'h0, 8'd34, 1'b1);
    drain("post_rst");

    // Read-after-write with no gap.
    send(32'h0, 32'hCAFE0123, 4'h0, 4'hF, 8'd40, 1'b1);
    send(32'h0, 32'h0, 4'hF, 4'h0, 8'd41, 1'b1);
    drain("raw");

    // Randomized traffic over a small aliased word set, paced so the queue never fills.
    for (int w = 0; w < 8; w++) begin
      send(32'h300 + 32'(4 * w), $urandom, 4'h0, 4'hF, 8'(50 + w), 1'b1);
      repeat (2) @(negedge clk);
    end
    for (int n = 0; n < 60; n++) begin
      a = 32'h300 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3))
          + 32'($urandom_range(0, 3)) * 32'(MEM_WORDS * 4);
      send(a, $urandom, 4'($urandom), 4'($urandom), 8'($urandom), 1'b1);
      repeat ($urandom_range(2, 4)) @(negedge clk);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
